// File: rtl/aes128_pkg.sv
// AES-128 shared types, constants and GF(2^8) round-transform helpers.
// Pure combinational functions; no latency of their own.
// No flow control here; callers own all handshaking.
package aes128_pkg;
    localparam int NB      = 4;
    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int SCHED_W = 1408;

    typedef logic [7:0]         byte_t;
    typedef logic [31:0]        word_t;
    typedef logic [BLOCK_W-1:0] state_t;

    typedef enum logic {ST_IDLE, ST_RUN} fsm_e;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 in GF(2^8); zero maps to zero for free.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t sq;
        byte_t acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic byte_t rotl8(input byte_t a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(input byte_t a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte i of the block sits at bits [127-8i -: 8]; byte i is row i%4, column i/4.
    function automatic byte_t get_byte(input state_t s, input int i);
        return s[BLOCK_W-1-8*i -: 8];
    endfunction

    function automatic state_t round_key(input logic [SCHED_W-1:0] ks, input logic [3:0] idx);
        return ks[SCHED_W-1-BLOCK_W*int'(idx) -: BLOCK_W];
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t r;
        for (int i = 0; i < 4*NB; i++) r[BLOCK_W-1-8*i -: 8] = sbox(get_byte(s, i));
        return r;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t r;
        for (int i = 0; i < 4*NB; i++) r[BLOCK_W-1-8*i -: 8] = inv_sbox(get_byte(s, i));
        return r;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < NB; c++)
            for (int w = 0; w < 4; w++)
                r[BLOCK_W-1-8*(w+4*c) -: 8] = get_byte(s, w + 4*((c + w) % NB));
        return r;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < NB; c++)
            for (int w = 0; w < 4; w++)
                r[BLOCK_W-1-8*(w+4*c) -: 8] = get_byte(s, w + 4*((c + NB - w) % NB));
        return r;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t r;
        byte_t  a0, a1, a2, a3;
        for (int c = 0; c < NB; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            r[BLOCK_W-1-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[BLOCK_W-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[BLOCK_W-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[BLOCK_W-1-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t r;
        byte_t  a0, a1, a2, a3;
        for (int c = 0; c < NB; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            r[BLOCK_W-1-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[BLOCK_W-1-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[BLOCK_W-1-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[BLOCK_W-1-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction
endpackage

// File: rtl/aes128_iter_crypt_if.sv
// Command/result bundle between the controller and the AES engine.
// Carries no state; latency is the engine's.
// start is level-sampled by the engine only while idle; no ready signal.
interface aes128_iter_crypt_if;
    import aes128_pkg::*;

    logic               start;
    logic               decrypt;
    state_t             data_in;
    logic [SCHED_W-1:0] round_keys;
    state_t             data_out;
    logic               busy;
    logic               done;
    logic [11:0]        bcd_out;

    modport master (
        output start, decrypt, data_in, round_keys,
        input  data_out, busy, done, bcd_out
    );

    modport slave (
        input  start, decrypt, data_in, round_keys,
        output data_out, busy, done, bcd_out
    );
endinterface

// File: rtl/bin_to_bcd8.sv
// 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// Combinational, zero latency.
// No flow control.
module bin_to_bcd8 (
    input  logic [7:0]  bin,
    output logic [11:0] bcd
);
    // Hundreds never exceeds 2, so only units and tens need the add-3 correction.
    always_comb begin
        bcd = 12'h000;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[10:0], bin[i]};
        end
    end
endmodule

// File: rtl/aes128_iter_crypt.sv
// Iterative AES-128 cipher (inverse cipher when AES_DECRYPT_EN is defined), one round per clock.
// Latency: 11 cycles from accepted start to the done pulse; data_out updates with done.
// start is ignored while busy (no queue); without AES_DECRYPT_EN a decrypt start is ignored.
module aes128_iter_crypt #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    aes128_iter_crypt_if.slave bus
);
    import aes128_pkg::*;

    if (NK != aes128_pkg::NK || NR != aes128_pkg::NR) begin : g_bad_cfg
        $error("aes128_iter_crypt: only NK=4 and NR=10 are supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_e        fsm_q, fsm_d;
    logic [3:0]  round_q, round_d;
    state_t      blk_q, blk_d;
    state_t      res_q, res_d;
    logic        done_q, done_d;
    logic        start_ok;
    logic [3:0]  rk_idx;
    state_t      rk_cur;
    state_t      rk_first;
    state_t      enc_res;
    state_t      round_res;
    logic [11:0] bcd;

`ifdef AES_DECRYPT_EN
    logic        mode_q, mode_d;
    state_t      dec_res;

    assign start_ok = bus.start;
    assign rk_idx   = mode_q ? (LAST_ROUND - round_q) : round_q;
    assign rk_first = bus.decrypt ? round_key(bus.round_keys, LAST_ROUND)
                                  : round_key(bus.round_keys, 4'd0);

    // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns except last.
    always_comb begin
        dec_res = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_cur;
        if (round_q != LAST_ROUND) dec_res = inv_mix_columns(dec_res);
    end

    assign round_res = mode_q ? dec_res : enc_res;

    // Mode is latched with an accepted start and held through the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= 1'b0;
        else        mode_q <= mode_d;
    end
`else
    // Without the inverse datapath, a decrypt request never leaves idle.
    assign start_ok  = bus.start & ~bus.decrypt;
    assign rk_idx    = round_q;
    assign rk_first  = round_key(bus.round_keys, 4'd0);
    assign round_res = enc_res;
`endif

    assign rk_cur = round_key(bus.round_keys, rk_idx);

    // Forward round: SubBytes, ShiftRows, MixColumns except last, AddRoundKey.
    always_comb begin
        enc_res = shift_rows(sub_bytes(blk_q));
        if (round_q != LAST_ROUND) enc_res = mix_columns(enc_res);
        enc_res = enc_res ^ rk_cur;
    end

    // Next-state: idle waits for an acceptable start; run steps one round per cycle.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        res_d   = res_q;
        done_d  = 1'b0;
`ifdef AES_DECRYPT_EN
        mode_d  = mode_q;
`endif
        case (fsm_q)
            ST_IDLE: begin
                if (start_ok) begin
                    fsm_d   = ST_RUN;
                    round_d = 4'd1;
                    blk_d   = bus.data_in ^ rk_first;
`ifdef AES_DECRYPT_EN
                    mode_d  = bus.decrypt;
`endif
                end
            end
            ST_RUN: begin
                blk_d = round_res;
                if (round_q == LAST_ROUND) begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                    res_d   = round_res;
                    done_d  = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    bin_to_bcd8 u_bcd (
        .bin (res_q[7:0]),
        .bcd (bcd)
    );

    assign bus.data_out = res_q;
    assign bus.busy     = (fsm_q == ST_RUN);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd;
endmodule

// File: tb/tb_aes128_iter_crypt.sv
module tb_aes128_iter_crypt;
    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes128_iter_crypt_if bus ();

    aes128_iter_crypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  bcd_in;
    logic [11:0] bcd_res;

    bin_to_bcd8 u_bcd_ref (
        .bin (bcd_in),
        .bcd (bcd_res)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] expt[256];
    int         logt[256];
    logic [7:0] sb[256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference field arithmetic via log/antilog tables over generator 0x03.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return expt[(logt[a] + logt[b]) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] e;
        logic [7:0] inv;
        logic [7:0] c;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            expt[i] = e;
            logt[e] = i;
            e = e ^ xt(e);
        end
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : expt[(255 - logt[a]) % 255];
            for (int b = 0; b < 8; b++)
                sb[a][b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w[44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [1407:0] ks);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[1407-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[w+4*c] = t[w + 4*((c + w) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[1407-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // Called at a falling edge; start is seen by exactly one rising edge.
    task automatic launch(input logic [127:0] din, input logic dec);
        bus.data_in = din;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output logic busy_seen);
        lat = lat0;
        busy_seen = bus.busy;
        while (!bus.done && lat < 30) begin
            @(negedge clk);
            lat++;
            busy_seen = busy_seen | bus.busy;
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1407:0] ks;
        logic [127:0]  pt, ct, key, prev, exp;
        logic          bs, dec;
        int            lat, cnt;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.decrypt    = 1'b0;
        bus.data_in    = '0;
        bus.round_keys = '0;
        bcd_in         = 8'h00;
        build_tables();
        repeat (3) @(negedge clk);

        check("rst_busy", 128'(bus.busy), 128'(1'b0));
        check("rst_done", 128'(bus.done), 128'(1'b0));
        check("rst_dout", bus.data_out, 128'h0);
        check("rst_bcd", 128'(bus.bcd_out), 128'(12'h000));
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1 encrypt
        ks = expand_key(C1_KEY);
        bus.round_keys = ks;
        check("model_rk10", ks[127:0], C1_RK10);
        check("model_c1", model_enc(C1_PT, ks), C1_CT);
        launch(C1_PT, 1'b0);
        check("c1_busy_t1", 128'(bus.busy), 128'(1'b1));
        check("c1_dout_hidden", bus.data_out, 128'h0);
        wait_done(1, lat, bs);
        check("c1_latency", 128'(lat), 128'(11));
        check("c1_dout", bus.data_out, C1_CT);
        check("c1_bcd", 128'(bus.bcd_out), 128'(12'h090));
        check("c1_busy_at_done", 128'(bus.busy), 128'(1'b0));
        @(negedge clk);
        check("c1_done_pulse", 128'(bus.done), 128'(1'b0));

        // Decrypt round trip (or ignored when the inverse path is absent)
        launch(C1_CT, 1'b1);
        wait_done(1, lat, bs);
`ifdef AES_DECRYPT_EN
        check("dec_latency", 128'(lat), 128'(11));
        check("dec_dout", bus.data_out, C1_PT);
        check("dec_bcd", 128'(bus.bcd_out), 128'(12'h255));
`else
        check("dec_ign_done", 128'(lat < 30), 128'(1'b0));
        check("dec_ign_busy", 128'(bs), 128'(1'b0));
        check("dec_ign_dout", bus.data_out, C1_CT);
`endif
        @(negedge clk);

        // Start while busy is dropped, not queued
        launch(C1_PT, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.data_in = ~C1_PT;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done(4, lat, bs);
        check("busy_latency", 128'(lat), 128'(11));
        check("busy_dout", bus.data_out, C1_CT);
        count_dones(15, cnt);
        check("busy_no_queue", 128'(cnt), 128'(0));

        // Reset mid-operation
        pt = {$urandom, $urandom, $urandom, $urandom};
        launch(pt, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dout", bus.data_out, 128'h0);
        check("rst_mid_busy", 128'(bus.busy), 128'(1'b0));
        check("rst_mid_done", 128'(bus.done), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(15, cnt);
        check("rst_mid_no_done", 128'(cnt), 128'(0));
        launch(C1_PT, 1'b0);
        wait_done(1, lat, bs);
        check("rst_fresh_latency", 128'(lat), 128'(11));
        check("rst_fresh_dout", bus.data_out, C1_CT);
        @(negedge clk);

        // Back-to-back: second start in the done cycle
        pt = {$urandom, $urandom, $urandom, $urandom};
        launch(C1_PT, 1'b0);
        wait_done(1, lat, bs);
        check("b2b_lat1", 128'(lat), 128'(11));
        launch(pt, 1'b0);
        wait_done(1, lat, bs);
        check("b2b_lat2", 128'(lat), 128'(11));
        check("b2b_dout2", bus.data_out, model_enc(pt, ks));
        @(negedge clk);

        // Randomized keys, data and direction
        for (int it = 0; it < 12; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            ks  = expand_key(key);
            bus.round_keys = ks;
            prev = bus.data_out;
            if (!dec) begin
                exp = model_enc(pt, ks);
                launch(pt, 1'b0);
                wait_done(1, lat, bs);
                check("rnd_enc_latency", 128'(lat), 128'(11));
                check("rnd_enc_dout", bus.data_out, exp);
                check("rnd_enc_bcd", 128'(bus.bcd_out), 128'(to_bcd(int'(exp[7:0]))));
            end else begin
                ct = model_enc(pt, ks);
                launch(ct, 1'b1);
                wait_done(1, lat, bs);
`ifdef AES_DECRYPT_EN
                check("rnd_dec_latency", 128'(lat), 128'(11));
                check("rnd_dec_dout", bus.data_out, pt);
                check("rnd_dec_bcd", 128'(bus.bcd_out), 128'(to_bcd(int'(pt[7:0]))));
`else
                check("rnd_dec_ign_done", 128'(lat < 30), 128'(1'b0));
                check("rnd_dec_ign_busy", 128'(bs), 128'(1'b0));
                check("rnd_dec_ign_dout", bus.data_out, prev);
`endif
            end
            @(negedge clk);
        end

        // Full sweep of the BCD converter
        for (int v = 0; v < 256; v++) begin
            bcd_in = 8'(v);
            #1;
            check("bcd_sweep", 128'(bcd_res), 128'(to_bcd(v)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
